// File: rtl/ooo_pkg.sv
// Shared out-of-order front-end types and constants.
// Fetch queue entries carry the instruction word and its PC.
package ooo_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INST = 32'd0;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// 2-wide fetch queue: captures fetched instruction pairs tagged with PC and
// presents the two oldest entries to decode in program order.
module fetch_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] instA,
  input  logic [XLEN-1:0] instB,
  output logic            fetch_ready,
  output logic            dec_valid_a,
  output logic [XLEN-1:0] dec_inst_a,
  output logic [XLEN-1:0] dec_pc_a,
  output logic            dec_valid_b,
  output logic [XLEN-1:0] dec_inst_b,
  output logic [XLEN-1:0] dec_pc_b,
  input  logic [1:0]      dec_take,
  output logic            overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic [PW-1:0]   head_p1;
  logic [CW-1:0]   free_slots;
  logic            enq_ok;
  logic            a_live, b_live;
  logic [1:0]      n_enq;
  logic [1:0]      n_deq;
  logic [CW-1:0]   count_next;
  fq_entry_t       wr0, wr1;

  assign head_p1    = head_q + PW'(1);
  assign free_slots = CW'(DEPTH) - count_q;

  // Ready uses the pre-dequeue count, so it never depends on dec_take.
  assign fetch_ready = (free_slots >= CW'(2));

  assign dec_valid_a = (count_q >= CW'(1));
  assign dec_valid_b = (count_q >= CW'(2));
  assign dec_inst_a  = dec_valid_a ? mem[head_q].inst  : NOP_INST;
  assign dec_pc_a    = dec_valid_a ? mem[head_q].pc    : '0;
  assign dec_inst_b  = dec_valid_b ? mem[head_p1].inst : NOP_INST;
  assign dec_pc_b    = dec_valid_b ? mem[head_p1].pc   : '0;
  assign overflow    = overflow_q;

  always_comb begin
    enq_ok = fetch_valid && fetch_ready && !flush;
    a_live = (instA != NOP_INST);
    b_live = (instB != NOP_INST);
    wr0.inst = instA;
    wr0.pc   = fetch_pc;
    wr1.inst = instB;
    wr1.pc   = fetch_pc + XLEN'(INST_BYTES);
    n_enq    = 2'd0;
    if (enq_ok) begin
      n_enq = {1'b0, a_live} + {1'b0, b_live};
      // Single surviving instB slides down to the tail slot.
      if (!a_live) wr0 = wr1;
    end
    if (CW'(dec_take) > count_q) n_deq = count_q[1:0];
    else                         n_deq = dec_take;
    if (flush) n_deq = 2'd0;
    count_next = count_q - CW'(n_deq) + CW'(n_enq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fetch_valid && !fetch_ready) overflow_q <= 1'b1;
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PW'(n_deq);
        tail_q  <= tail_q + PW'(n_enq);
        count_q <= count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && n_enq != 2'd0) mem[tail_q] <= wr0;
    if (!reset && n_enq == 2'd2) mem[tail_q + PW'(1)] <= wr1;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 8).
module tb_fetch_queue;
  import ooo_pkg::*;

  logic            clk = 1'b0;
  logic            reset, flush, fetch_valid;
  logic [XLEN-1:0] fetch_pc, instA, instB;
  logic            fetch_ready, dec_valid_a, dec_valid_b, overflow;
  logic [XLEN-1:0] dec_inst_a, dec_pc_a, dec_inst_b, dec_pc_b;
  logic [1:0]      dec_take;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .instA(instA), .instB(instB), .fetch_ready(fetch_ready),
    .dec_valid_a(dec_valid_a), .dec_inst_a(dec_inst_a), .dec_pc_a(dec_pc_a),
    .dec_valid_b(dec_valid_b), .dec_inst_b(dec_inst_b), .dec_pc_b(dec_pc_b),
    .dec_take(dec_take), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; fetch_valid = 0; fetch_pc = '0;
    instA = '0; instB = '0; dec_take = 2'd0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    fetch_valid = 1; fetch_pc = pc; instA = a; instB = b;
  endtask

  task automatic test_reset();
    idle(); reset = 1; cyc(); cyc(); reset = 0;
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", fetch_ready); end
    total++; if (dec_valid_a !== 1'b0 || dec_valid_b !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b%0b exp=00", dec_valid_a, dec_valid_b); end
    total++; if ({dec_inst_a, dec_pc_a, dec_inst_b, dec_pc_b} !== 128'd0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h exp=0", dec_inst_a, dec_pc_a, dec_inst_b, dec_pc_b); end
    total++; if (overflow !== 1'b0 || dut.count_q !== 4'd0) begin bad++; $display("FAIL rst_state ovf=%0b count=%0d exp 0/0", overflow, dut.count_q); end
  endtask

  task automatic test_basic_push();
    push(32'h0, 32'h00500093, 32'h00A00113); cyc(); idle();
    total++; if (dec_valid_a !== 1'b1 || dec_valid_b !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b%0b exp=11", dec_valid_a, dec_valid_b); end
    total++; if (dec_pc_a !== 32'h0 || dec_pc_b !== 32'h4) begin bad++; $display("FAIL basic_pc got=%h/%h exp=0/4", dec_pc_a, dec_pc_b); end
    total++; if (dec_inst_a !== 32'h00500093 || dec_inst_b !== 32'h00A00113) begin bad++; $display("FAIL basic_inst got=%h/%h", dec_inst_a, dec_inst_b); end
    total++; if (dut.count_q !== 4'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", dut.count_q); end
    flush = 1; cyc(); idle();
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(8*i), 32'h1001 + 32'(2*i), 32'h1002 + 32'(2*i));
      cyc();
    end
    idle();
    total++; if (fetch_ready !== 1'b0 || dut.count_q !== 4'd8) begin bad++; $display("FAIL full ready=%0b count=%0d exp 0/8", fetch_ready, dut.count_q); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_noovf got=%0b exp=0", overflow); end
    push(32'h200, 32'hBAD1, 32'hBAD2); cyc(); idle();
    total++; if (overflow !== 1'b1 || dut.count_q !== 4'd8) begin bad++; $display("FAIL ovf ovf=%0b count=%0d exp 1/8", overflow, dut.count_q); end
    total++; if (dec_inst_a !== 32'h1001 || dec_pc_a !== 32'h100 || dec_inst_b !== 32'h1002) begin bad++; $display("FAIL ovf_contents got=%h/%h/%h", dec_inst_a, dec_pc_a, dec_inst_b); end
    // Dequeue while full still happens.
    dec_take = 2'd1; cyc(); idle();
    total++; if (dut.count_q !== 4'd7 || dec_inst_a !== 32'h1002 || dec_pc_a !== 32'h104) begin bad++; $display("FAIL full_deq count=%0d inst=%h pc=%h", dut.count_q, dec_inst_a, dec_pc_a); end
    flush = 1; cyc(); idle();
    total++; if (overflow !== 1'b1 || dut.count_q !== 4'd0 || fetch_ready !== 1'b1) begin bad++; $display("FAIL flush_keep_ovf ovf=%0b count=%0d rdy=%0b", overflow, dut.count_q, fetch_ready); end
    reset = 1; cyc(); idle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_zero_words();
    push(32'h10, 32'h0, 32'h13); cyc(); idle();
    total++; if (dut.count_q !== 4'd1 || dec_inst_a !== 32'h13 || dec_pc_a !== 32'h14 || dec_valid_b !== 1'b0) begin bad++; $display("FAIL zero_a count=%0d inst=%h pc=%h vb=%0b", dut.count_q, dec_inst_a, dec_pc_a, dec_valid_b); end
    push(32'h18, 32'h0, 32'h0); cyc(); idle();
    total++; if (dut.count_q !== 4'd1) begin bad++; $display("FAIL zero_both count=%0d exp=1", dut.count_q); end
    dec_take = 2'd2; cyc(); idle();
    total++; if (dut.count_q !== 4'd0 || dec_valid_a !== 1'b0) begin bad++; $display("FAIL clamp count=%0d va=%0b exp 0/0", dut.count_q, dec_valid_a); end
  endtask

  task automatic test_back_to_back();
    push(32'h20, 32'h21, 32'h25); cyc();
    push(32'h28, 32'h29, 32'h0); cyc(); idle();
    total++; if (dut.count_q !== 4'd3) begin bad++; $display("FAIL b2b_fill count=%0d exp=3", dut.count_q); end
    push(32'h30, 32'h31, 32'h35); dec_take = 2'd2; cyc(); idle();
    total++; if (dut.count_q !== 4'd3 || dec_inst_a !== 32'h29 || dec_inst_b !== 32'h31 || dec_pc_b !== 32'h30) begin bad++; $display("FAIL b2b_mix count=%0d a=%h b=%h pcb=%h", dut.count_q, dec_inst_a, dec_inst_b, dec_pc_b); end
    dec_take = 2'd2; cyc(); idle();
    total++; if (dut.count_q !== 4'd1 || dec_inst_a !== 32'h35 || dec_pc_a !== 32'h34) begin bad++; $display("FAIL b2b_drain count=%0d a=%h pc=%h", dut.count_q, dec_inst_a, dec_pc_a); end
    dec_take = 2'd2; cyc(); idle();
    total++; if (dut.count_q !== 4'd0) begin bad++; $display("FAIL b2b_empty count=%0d exp=0", dut.count_q); end
  endtask

  task automatic test_wrap();
    // Pointers sit at 6 here; the second push straddles slots 7 and 0.
    total++; if (dut.tail_q !== 3'd6) begin bad++; $display("FAIL wrap_pre tail=%0d exp=6", dut.tail_q); end
    push(32'h40, 32'h41, 32'h0); cyc();
    push(32'h48, 32'h49, 32'h4D); cyc(); idle();
    total++; if (dut.count_q !== 4'd3 || dec_inst_a !== 32'h41 || dec_inst_b !== 32'h49 || dut.tail_q !== 3'd1) begin bad++; $display("FAIL wrap_push count=%0d a=%h b=%h tail=%0d", dut.count_q, dec_inst_a, dec_inst_b, dut.tail_q); end
    dec_take = 2'd1; cyc(); idle();
    total++; if (dec_inst_a !== 32'h49 || dec_pc_a !== 32'h48 || dec_inst_b !== 32'h4D || dec_pc_b !== 32'h4C) begin bad++; $display("FAIL wrap_order a=%h/%h b=%h/%h", dec_inst_a, dec_pc_a, dec_inst_b, dec_pc_b); end
    dec_take = 2'd2; cyc(); idle();
    total++; if (dut.count_q !== 4'd0) begin bad++; $display("FAIL wrap_empty count=%0d exp=0", dut.count_q); end
  endtask

  task automatic test_flush();
    push(32'h50, 32'h51, 32'h55); cyc();
    push(32'h58, 32'h59, 32'h5D); cyc();
    push(32'h60, 32'h61, 32'h0); cyc(); idle();
    total++; if (dut.count_q !== 4'd5) begin bad++; $display("FAIL flush_pre count=%0d exp=5", dut.count_q); end
    flush = 1; push(32'h68, 32'h69, 32'h6D); dec_take = 2'd2; cyc(); idle();
    total++; if (dut.count_q !== 4'd0 || dec_valid_a !== 1'b0 || fetch_ready !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL flush count=%0d va=%0b rdy=%0b ovf=%0b", dut.count_q, dec_valid_a, fetch_ready, overflow); end
  endtask

  task automatic test_reset_mid();
    push(32'hFFFF_FFFC, 32'h71, 32'h75); cyc(); idle();
    total++; if (dec_pc_a !== 32'hFFFF_FFFC || dec_pc_b !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h/%h exp=fffffffc/0", dec_pc_a, dec_pc_b); end
    reset = 1; flush = 1; push(32'h80, 32'h81, 32'h85); dec_take = 2'd1; cyc(); idle();
    total++; if (dut.count_q !== 4'd0 || dut.head_q !== 3'd0 || dut.tail_q !== 3'd0 || dec_valid_a !== 1'b0 || dec_valid_b !== 1'b0 || fetch_ready !== 1'b1 || overflow !== 1'b0 || dec_inst_a !== 32'd0 || dec_pc_a !== 32'd0) begin
      bad++; $display("FAIL reset_mid count=%0d head=%0d tail=%0d va=%0b vb=%0b rdy=%0b ovf=%0b", dut.count_q, dut.head_q, dut.tail_q, dec_valid_a, dec_valid_b, fetch_ready, overflow);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_push();
    test_full_overflow();
    test_zero_words();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
